// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the pipeline memory controller.
//   - default address / data widths used by the IF and MEM clients
//   - mem_len codes (LEN_B / LEN_H / LEN_W; code 3 is reserved and acts as a word)
//   - controller state encoding
//   - len_bytes(): mem_len code -> number of byte transfers
package mem_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    IF_READ,
    MEM_READ,
    MEM_WRITE,
    DONE
  } state_t;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_seq.sv
// mem_ctrl_byte_seq: serialises one access into 1, 2 or 4 byte transfers on the
// byte-wide RAM bus and assembles little-endian read words.
//   clk, rst     clock, synchronous active-high reset
//   start        load a new transaction (base, nbytes, is_wr, wdata)
//   abort        drop the current read, clear the byte counter
//   rd_active    controller is in a read state
//   wr_active    controller is in the write state
//   ram_din      RAM read byte, valid one cycle after its address
//   ram_addr     registered RAM byte address (holds when idle)
//   ram_wr       registered RAM write strobe
//   ram_dout     registered RAM write byte
//   word_next    assembled read word including the byte arriving this cycle
//   fin          last step of the transaction happens this cycle
module mem_ctrl_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  rd_active,
  input  logic                  wr_active,
  input  logic                  is_wr,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [2:0]            nbytes,
  input  logic [31:0]           wdata,
  input  logic [7:0]            ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  output logic [31:0]           word_next,
  output logic                  fin
);

  // cnt is the index of the byte whose address is on the bus; during reads
  // ram_din carries byte cnt-1, so a read needs nbytes+1 steps.
  logic [2:0]  cnt;
  logic [2:0]  n_q;
  logic [23:0] wsh;
  logic [31:0] word;

  always_comb begin
    word_next = word;
    case (cnt)
      3'd1:    word_next[7:0]   = ram_din;
      3'd2:    word_next[15:8]  = ram_din;
      3'd3:    word_next[23:16] = ram_din;
      3'd4:    word_next[31:24] = ram_din;
      default: ;
    endcase
  end

  always_comb begin
    fin = 1'b0;
    if (rd_active)      fin = (cnt == n_q);
    else if (wr_active) fin = (cnt == n_q - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      n_q      <= '0;
      wsh      <= '0;
      word     <= '0;
      ram_addr <= '0;
      ram_wr   <= 1'b0;
      ram_dout <= '0;
    end else if (start) begin
      cnt      <= '0;
      n_q      <= nbytes;
      word     <= '0;
      ram_addr <= base;
      ram_wr   <= is_wr;
      ram_dout <= wdata[7:0];
      wsh      <= wdata[31:8];
    end else if (abort) begin
      cnt <= '0;
    end else if (rd_active) begin
      word <= word_next;
      if (fin) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 3'd1;
        // Keep the last address on the bus once all bytes have been issued.
        if (cnt + 3'd1 < n_q) ram_addr <= ram_addr + ADDR_WIDTH'(1);
      end
    end else if (wr_active) begin
      if (fin) begin
        cnt    <= '0;
        ram_wr <= 1'b0;
      end else begin
        cnt      <= cnt + 3'd1;
        ram_addr <= ram_addr + ADDR_WIDTH'(1);
        ram_dout <= wsh[7:0];
        wsh      <= {8'h00, wsh[23:8]};
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port memory controller between the pipeline (IF fetches and
// MEM loads/stores) and the byte-wide unified RAM.
//   clk, rst                    clock, synchronous active-high reset
//   if_enable/if_addr           fetch request (level-held until if_done)
//   branch_enable               flush: aborts or suppresses the IF transaction
//   if_inst/if_done/busy_if     fetch result, done pulse, in-flight flag
//   mem_enable/mem_wr/mem_len/
//   mem_addr/mem_wdata          load/store request (level-held until mem_done)
//   mem_rdata/mem_done/busy_mem load result (zero-extended), done pulse, busy
//   ram_addr/ram_wr/ram_dout    RAM byte bus, ram_din read byte (1-cycle latency)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_enable,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  branch_enable,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic                  if_done,
  output logic                  busy_if,
  input  logic                  mem_enable,
  input  logic                  mem_wr,
  input  logic [1:0]            mem_len,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_done,
  output logic                  busy_mem,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  state_t state;
  logic   cur_mem;

  logic                  accept_mem;
  logic                  accept_if;
  logic                  start;
  logic                  abort;
  logic                  rd_active;
  logic                  wr_active;
  logic                  is_wr;
  logic                  fin;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            nbytes;
  logic [31:0]           word_next;

  // MEM wins arbitration; a flushed IF request is never accepted.
  always_comb begin
    accept_mem = (state == IDLE) && mem_enable;
    accept_if  = (state == IDLE) && !mem_enable && if_enable && !branch_enable;
    start      = accept_mem || accept_if;
    base       = mem_enable ? mem_addr : if_addr;
    nbytes     = mem_enable ? len_bytes(mem_len) : 3'd4;
    is_wr      = mem_enable && mem_wr;
    abort      = (state == IF_READ) && branch_enable;
    rd_active  = (state == IF_READ) || (state == MEM_READ);
    wr_active  = (state == MEM_WRITE);
  end

  mem_ctrl_byte_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rd_active (rd_active),
    .wr_active (wr_active),
    .is_wr     (is_wr),
    .base      (base),
    .nbytes    (nbytes),
    .wdata     (mem_wdata),
    .ram_din   (ram_din),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_dout  (ram_dout),
    .word_next (word_next),
    .fin       (fin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_mem   <= 1'b0;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_mem) begin
            cur_mem <= 1'b1;
            state   <= mem_wr ? MEM_WRITE : MEM_READ;
          end else if (accept_if) begin
            cur_mem <= 1'b0;
            state   <= IF_READ;
          end
        end
        IF_READ: begin
          if (branch_enable) begin
            state <= IDLE;
          end else if (fin) begin
            if_inst <= word_next;
            state   <= DONE;
          end
        end
        MEM_READ: begin
          if (fin) begin
            mem_rdata <= word_next;
            state     <= DONE;
          end
        end
        MEM_WRITE: begin
          if (fin) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status is decoded from state; a flush in the IF DONE cycle hides if_done.
  assign busy_if  = (state == IF_READ);
  assign busy_mem = (state == MEM_READ) || (state == MEM_WRITE) || ((state == DONE) && cur_mem);
  assign if_done  = (state == DONE) && !cur_mem && !branch_enable;
  assign mem_done = (state == DONE) && cur_mem;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a 4 KiB byte RAM
// model (address bits [11:0], one-cycle read latency).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        branch_enable;
  logic [31:0] if_inst;
  logic        if_done;
  logic        busy_if;
  logic        mem_enable;
  logic        mem_wr;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        busy_mem;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  logic [7:0]  ram [0:4095];
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [7:0]  ld_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_enable     (if_enable),
    .if_addr       (if_addr),
    .branch_enable (branch_enable),
    .if_inst       (if_inst),
    .if_done       (if_done),
    .busy_if       (busy_if),
    .mem_enable    (mem_enable),
    .mem_wr        (mem_wr),
    .mem_len       (mem_len),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_done      (mem_done),
    .busy_mem      (busy_mem),
    .ram_addr      (ram_addr),
    .ram_wr        (ram_wr),
    .ram_dout      (ram_dout),
    .ram_din       (ram_din)
  );

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    ram_din <= ram[ram_addr[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
    if_addr   = addr;
    if_enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) check("if_ram_addr", ram_addr, addr + 32'(c - 1));
      check("if_ram_wr", 32'(ram_wr), 32'd0);
      check("if_busy", 32'(busy_if), 32'(c <= 5));
      check("if_done", 32'(if_done), 32'(c == 6));
      if (c == 6) begin
        check("if_inst", if_inst, exp);
        if_enable = 1'b0;
      end
    end
    tick();
    check("if_done_after", 32'(if_done), 32'd0);
    check("if_busy_after", 32'(busy_if), 32'd0);
  endtask

  task automatic mem_access(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp);
    int          n;
    int          dc;
    logic [31:0] sh;
    n  = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    dc = wr ? n + 1 : n + 2;
    mem_wr     = wr;
    mem_len    = len;
    mem_addr   = addr;
    mem_wdata  = wdata;
    mem_enable = 1'b1;
    for (int c = 1; c <= dc; c++) begin
      tick();
      if (c <= n) check("mem_ram_addr", ram_addr, addr + 32'(c - 1));
      check("mem_ram_wr", 32'(ram_wr), 32'(wr && (c <= n)));
      if (wr && c <= n) begin
        sh = wdata >> (8 * (c - 1));
        check("mem_ram_dout", 32'(ram_dout), 32'(sh[7:0]));
      end
      check("mem_busy", 32'(busy_mem), 32'd1);
      check("mem_done", 32'(mem_done), 32'(c == dc));
      if (c == dc) begin
        if (!wr) check("mem_rdata", mem_rdata, exp);
        mem_enable = 1'b0;
      end
    end
    tick();
    check("mem_done_after", 32'(mem_done), 32'd0);
    check("mem_busy_after", 32'(busy_mem), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    if_enable = 1'b0; if_addr = '0; branch_enable = 1'b0;
    mem_enable = 1'b0; mem_wr = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    tick();
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_done", {30'd0, if_done, mem_done}, 32'd0);
    check("rst_busy", {30'd0, busy_if, busy_mem}, 32'd0);
    check("rst_ram", {ram_addr[22:0], ram_wr, ram_dout}, 32'd0);

    poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
    poke(12'h3FF, 8'h80);
    poke(12'h400, 8'h93); poke(12'h401, 8'h00); poke(12'h402, 8'h10); poke(12'h403, 8'h00);
    poke(12'h500, 8'h01); poke(12'h501, 8'h02); poke(12'h502, 8'h03); poke(12'h503, 8'h04);
    poke(12'hFFF, 8'h11); poke(12'h000, 8'h22);
    poke(12'h602, 8'hA5);
    rst = 1'b0;
    tick();

    // Instruction fetch
    fetch(32'h0000_0100, 32'h0000_0513);

    // Store word, then verify RAM contents
    mem_access(1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'd0);
    check("st_b0", 32'(ram[12'h200]), 32'h0000_00EF);
    check("st_b1", 32'(ram[12'h201]), 32'h0000_00BE);
    check("st_b2", 32'(ram[12'h202]), 32'h0000_00AD);
    check("st_b3", 32'(ram[12'h203]), 32'h0000_00DE);

    // Short and misaligned loads, address wrap
    mem_access(1'b0, 2'd0, 32'h0000_03FF, 32'd0, 32'h0000_0080);
    mem_access(1'b0, 2'd1, 32'h0000_03FF, 32'd0, 32'h0000_9380);
    mem_access(1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0, 32'h0000_2211);
    mem_access(1'b0, 2'd3, 32'h0000_0400, 32'd0, 32'h0010_0093);
    check("if_inst_hold", if_inst, 32'h0000_0513);

    // Simultaneous requests: MEM first, IF accepted the cycle after DONE
    mem_wr = 1'b0; mem_len = 2'd2; mem_addr = 32'h0000_0200; mem_enable = 1'b1;
    if_addr = 32'h0000_0100; if_enable = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 4) check("arb_mem_addr", ram_addr, 32'h0000_0200 + 32'(c - 1));
      if (c >= 8 && c <= 11) check("arb_if_addr", ram_addr, 32'h0000_0100 + 32'(c - 8));
      check("arb_busy_if", 32'(busy_if), 32'(c >= 8 && c <= 12));
      check("arb_mem_done", 32'(mem_done), 32'(c == 6));
      check("arb_if_done", 32'(if_done), 32'(c == 13));
      if (c == 6) begin
        check("arb_rdata", mem_rdata, 32'hDEAD_BEEF);
        mem_enable = 1'b0;
      end
      if (c == 13) begin
        check("arb_inst", if_inst, 32'h0000_0513);
        if_enable = 1'b0;
      end
    end
    tick();

    // Flush in C3 of a fetch, then refetch 0x400
    if_addr = 32'h0000_0500; if_enable = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("fl_busy", 32'(busy_if), 32'd1);
      check("fl_done", 32'(if_done), 32'd0);
    end
    branch_enable = 1'b1;
    if_addr = 32'h0000_0400;
    tick();
    check("fl_abort_busy", 32'(busy_if), 32'd0);
    check("fl_abort_done", 32'(if_done), 32'd0);
    branch_enable = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) check("fl_ram_addr", ram_addr, 32'h0000_0400 + 32'(c - 1));
      check("fl_if_done", 32'(if_done), 32'(c == 6));
      if (c == 6) begin
        check("fl_inst", if_inst, 32'h0010_0093);
        if_enable = 1'b0;
      end
    end
    tick();

    // Flush during the IF DONE cycle suppresses if_done
    if_addr = 32'h0000_0500; if_enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("fd_done_early", 32'(if_done), 32'd0);
    end
    tick();
    branch_enable = 1'b1;
    #1;
    check("fd_done_masked", 32'(if_done), 32'd0);
    if_enable = 1'b0;
    tick();
    branch_enable = 1'b0;
    check("fd_done_after", 32'(if_done), 32'd0);

    // Reset in the middle of a word store
    mem_wr = 1'b1; mem_len = 2'd2; mem_addr = 32'h0000_0600; mem_wdata = 32'h1234_5678;
    mem_enable = 1'b1;
    tick();
    check("rs_wr_c1", 32'(ram_wr), 32'd1);
    tick();
    check("rs_addr_c2", ram_addr, 32'h0000_0601);
    rst = 1'b1;
    mem_enable = 1'b0;
    tick();
    check("rs_ram_wr", 32'(ram_wr), 32'd0);
    check("rs_ram_addr", ram_addr, 32'd0);
    check("rs_ram_dout", 32'(ram_dout), 32'd0);
    check("rs_status", {28'd0, if_done, mem_done, busy_if, busy_mem}, 32'd0);
    check("rs_if_inst", if_inst, 32'd0);
    check("rs_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("rs_no_done", 32'(mem_done), 32'd0);
    check("rs_b0", 32'(ram[12'h600]), 32'h0000_0078);
    check("rs_b1", 32'(ram[12'h601]), 32'h0000_0056);
    check("rs_b2", 32'(ram[12'h602]), 32'h0000_00A5);
    mem_access(1'b1, 2'd1, 32'h0000_0602, 32'h0000_BEEF, 32'd0);
    mem_access(1'b0, 2'd2, 32'h0000_0600, 32'd0, 32'hBEEF_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
